riscv_mem_stage: RTL and testbench
==================================

Name: riscv_mem_stage

Overview:
- MEM pipeline stage between EX and WB.
- Takes the EX result (ALU result/address, store data, load/store control, WB control fields) and performs loads and stores over a req/gnt/rvalid data-memory port.
- Extracts and sign- or zero-extends load data, forms byte enables for stores, and registers the result toward WB.
- Stalls EX with a valid/ready handshake while a memory transaction is outstanding.

Parameters:
DATA_WIDTH, 32, datapath/memory data width; only 32 is supported.
ADDR_WIDTH, 5, register-file index width for dest_reg.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  discard the current/next instruction's WB result
ex_valid_i  in  1  EX presents an instruction
ex_ready_o  out  1  MEM accepts the instruction this cycle
ex_alu_result_i  in  32  ALU result; the address for loads and stores
ex_mem_wdata_i  in  32  store data (rs2)
ex_mem_we_i  in  1  store
ex_mem_re_i  in  1  load
ex_mem_funct3_i  in  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW codes)
ex_reg_we_i  in  1  WB write enable
ex_wdata_mux_i  in  WDATA_MUX_WIDTH  WB source select (WDATA_ALU / WDATA_MEM)
ex_dest_reg_i  in  ADDR_WIDTH  destination register
data_req_o  out  1  memory request
data_gnt_i  in  1  request granted
data_addr_o  out  32  word-aligned address
data_we_o  out  1  write
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-aligned write data
data_rvalid_i  in  1  response valid (asserted for loads and for stores)
data_rdata_i  in  32  read data
wb_valid_o  out  1  WB outputs are valid
wb_reg_we_o  out  1  WB write enable
wb_wdata_mux_o  out  WDATA_MUX_WIDTH  WB source select
wb_dest_reg_o  out  ADDR_WIDTH  destination register
wb_alu_result_o  out  32  ALU result
wb_mem_data_o  out  32  extended load data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - Every wb_* output is 0.
  - data_req_o is 0.
- Upstream contract: EX holds all ex_* inputs stable from ex_valid_i until the cycle ex_ready_o=1.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE, non-memory instruction (ex_valid_i=1, re=we=0):
  - ex_ready_o=1 combinationally.
  - The instruction is registered to WB on the next edge with wb_valid_o=1.
  - Latency is 1 cycle.
- IDLE, memory instruction (ex_valid_i=1, re|we=1):
  - data_req_o=1 in the same cycle; ex_ready_o=0.
  - gnt=1 goes to WAIT_RVALID; gnt=0 goes to WAIT_GNT.
- WAIT_GNT:
  - req stays high; addr, we, be and wdata stay stable.
  - gnt goes to WAIT_RVALID.
- WAIT_RVALID:
  - req=0.
  - On rvalid: ex_ready_o=1 that cycle, the WB register loads (wb_mem_data_o = extended rdata for loads, 0 for stores), and the FSM returns to IDLE.
  - Minimum load/store latency is 2 cycles (req+gnt in cycle 0, rvalid in cycle 1, WB valid in cycle 2).
- wb_valid_o is 1 for exactly one cycle per completed instruction, otherwise 0. The WB register holds its other fields when not loading.
- Address and data lanes:
  - data_addr_o = {alu_result[31:2],2'b00}.
  - Byte offset = alu_result[1:0].
- Byte enables:
  - SB: 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - SH: 4'b0011<<{off[1],1'b0}, wdata = {2{wdata[15:0]}}.
  - SW: 4'b1111.
  - Loads: data_be_o=4'b1111.
- Load extraction (rdata shifted right by 8*off):
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: passthrough.
- Misalignment (macro undefined): word accesses ignore off; halfwords ignore off[0].
- Spurious data_rvalid_i in IDLE/WAIT_GNT is ignored.
- flush_i:
  - In IDLE it is sampled with the instruction.
  - In WAIT_* it is latched sticky until completion.
  - A flushed instruction still completes its bus transaction (no cancellation) and is accepted (ex_ready_o as usual), but wb_valid_o stays 0.
- Reset mid-transaction returns to IDLE; any later rvalid is ignored.

Optional Feature:
- Macro: RISCV_MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_o (1 bit).
  - An LH/LHU/SH with off[0]=1, or an LW/SW with off≠0, issues no request.
  - It completes in 1 cycle with ex_ready_o=1, wb_valid_o=0, and a 1-cycle pulse on misalign_o in the WB cycle.
- When undefined: the port is absent and accesses are silently truncated as above.

Decomposition:
- riscv_cpu_pkg gains:
  - typedef ex2mem_ctrl_t {mem_we, mem_re, funct3};
  - localparams MEM_IDLE/MEM_WAIT_GNT/MEM_WAIT_RVALID (2-bit state encoding).
  - The existing LB..LHU and SB..SW codes are reused for funct3.
- One sub-module: riscv_load_store_align (combinational), containing be/wdata generation and load extract/extend.
- The FSM and WB register stay in riscv_mem_stage.

Test Plan:
- Non-memory op with alu_result=0x1234 and dest=5 -> ex_ready_o=1 same cycle; next cycle wb_valid_o=1, wb_alu_result_o=0x1234, wb_dest_reg_o=5.
- LB at 0x103, gnt immediately, rdata=0x80FF_FF_FF one cycle later -> data_addr_o=0x100, be=4'b1111; wb_mem_data_o=0xFFFFFF80 two cycles after request; LBU on the same data -> 0x00000080.
- SH at 0x202, wdata=0xABCD1234, gnt delayed 3 cycles -> req held 4 cycles with stable addr 0x200, be=4'b1100, wdata=0x12341234; ex_ready_o=0 until rvalid.
- LW completes, then flush_i=1 on the next LW issued in IDLE -> the second transaction still runs on the bus; wb_valid_o stays 0 for it.
- rst_n low during WAIT_RVALID, then rvalid after release -> outputs 0, FSM IDLE, rvalid ignored, no wb_valid_o.
- With RISCV_MEM_MISALIGN_TRAP_EN: LW at 0x101 -> data_req_o never 1, misalign_o pulses once, wb_valid_o=0.

Source files
------------

// File: rtl/riscv_cpu_pkg.sv
// Shared CPU types and constants: WB source selects, load/store funct3 codes,
// MEM-stage state encoding and the EX->MEM memory control bundle.
package riscv_cpu_pkg;

  localparam int WDATA_MUX_WIDTH = 1;
  localparam logic [WDATA_MUX_WIDTH-1:0] WDATA_ALU = 1'b0;
  localparam logic [WDATA_MUX_WIDTH-1:0] WDATA_MEM = 1'b1;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t MEM_IDLE        = 2'd0;
  localparam mem_state_t MEM_WAIT_GNT    = 2'd1;
  localparam mem_state_t MEM_WAIT_RVALID = 2'd2;

  typedef struct packed {
    logic       mem_we;
    logic       mem_re;
    logic [2:0] funct3;
  } ex2mem_ctrl_t;

  // Halfwords need an even offset, words a zero offset; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return ((funct3[1:0] == 2'b01) && off[0]) || ((funct3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/riscv_load_store_align.sv
// Byte-lane steering for stores and load extract/extend; purely combinational.
// Misaligned halfword/word accesses are truncated to their natural boundary.
module riscv_load_store_align
  import riscv_cpu_pkg::*;
(
  input  ex2mem_ctrl_t ctrl,
  input  logic [1:0]   offset,
  input  logic [31:0]  wdata,
  input  logic [31:0]  rdata,
  output logic [3:0]   be,
  output logic [31:0]  wdata_lane,
  output logic [31:0]  load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    if (ctrl.mem_we) begin
      case (ctrl.funct3)
        SB: begin
          be         = 4'b0001 << offset;
          wdata_lane = {4{wdata[7:0]}};
        end
        SH: begin
          be         = 4'b0011 << {offset[1], 1'b0};
          wdata_lane = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    case (ctrl.funct3)
      LB:      ext = {{24{byte_sel[7]}}, byte_sel};
      LH:      ext = {{16{half_sel[15]}}, half_sel};
      LBU:     ext = {24'b0, byte_sel};
      LHU:     ext = {16'b0, half_sel};
      default: ext = rdata;
    endcase
  end

  // Stores report zero toward WB.
  assign load_data = ctrl.mem_re ? ext : 32'b0;

endmodule

// File: rtl/riscv_mem_stage.sv
// MEM stage: issues loads/stores on req/gnt/rvalid, registers the result to WB (1 cycle ALU, >=2 cycles memory).
// Holds ex_ready_o low while a transaction is outstanding; RISCV_MEM_MISALIGN_TRAP_EN adds misalign_o trapping.
module riscv_mem_stage
  import riscv_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       ex_valid_i,
  output logic                       ex_ready_o,
  input  logic [DATA_WIDTH-1:0]      ex_alu_result_i,
  input  logic [DATA_WIDTH-1:0]      ex_mem_wdata_i,
  input  logic                       ex_mem_we_i,
  input  logic                       ex_mem_re_i,
  input  logic [2:0]                 ex_mem_funct3_i,
  input  logic                       ex_reg_we_i,
  input  logic [WDATA_MUX_WIDTH-1:0] ex_wdata_mux_i,
  input  logic [ADDR_WIDTH-1:0]      ex_dest_reg_i,
  output logic                       data_req_o,
  input  logic                       data_gnt_i,
  output logic [DATA_WIDTH-1:0]      data_addr_o,
  output logic                       data_we_o,
  output logic [3:0]                 data_be_o,
  output logic [DATA_WIDTH-1:0]      data_wdata_o,
  input  logic                       data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      data_rdata_i,
  output logic                       wb_valid_o,
  output logic                       wb_reg_we_o,
  output logic [WDATA_MUX_WIDTH-1:0] wb_wdata_mux_o,
  output logic [ADDR_WIDTH-1:0]      wb_dest_reg_o,
  output logic [DATA_WIDTH-1:0]      wb_alu_result_o,
  output logic [DATA_WIDTH-1:0]      wb_mem_data_o
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  ,
  output logic                       misalign_o
`endif
);

  mem_state_t   state;
  logic         flush_q;
  ex2mem_ctrl_t ctrl;
  logic         is_mem;
  logic         misalign_hit;
  logic         issue;
  logic [31:0]  load_data;

  assign ctrl   = '{mem_we: ex_mem_we_i, mem_re: ex_mem_re_i, funct3: ex_mem_funct3_i};
  assign is_mem = ex_mem_we_i | ex_mem_re_i;

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  assign misalign_hit = ex_valid_i && is_mem && is_misaligned(ex_mem_funct3_i, ex_alu_result_i[1:0]);
`else
  assign misalign_hit = 1'b0;
`endif

  assign issue = ex_valid_i && is_mem && !misalign_hit;

  riscv_load_store_align u_align (
    .ctrl       (ctrl),
    .offset     (ex_alu_result_i[1:0]),
    .wdata      (ex_mem_wdata_i),
    .rdata      (data_rdata_i),
    .be         (data_be_o),
    .wdata_lane (data_wdata_o),
    .load_data  (load_data)
  );

  // Bus fields come straight from EX, which holds them until accepted.
  assign data_addr_o = {ex_alu_result_i[31:2], 2'b00};
  assign data_we_o   = ex_mem_we_i;

  always_comb begin
    data_req_o = 1'b0;
    ex_ready_o = 1'b0;
    case (state)
      MEM_IDLE: begin
        data_req_o = issue;
        ex_ready_o = ex_valid_i && !issue;
      end
      MEM_WAIT_GNT:    data_req_o = 1'b1;
      MEM_WAIT_RVALID: ex_ready_o = data_rvalid_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= MEM_IDLE;
      flush_q         <= 1'b0;
      wb_valid_o      <= 1'b0;
      wb_reg_we_o     <= 1'b0;
      wb_wdata_mux_o  <= '0;
      wb_dest_reg_o   <= '0;
      wb_alu_result_o <= '0;
      wb_mem_data_o   <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      if (ex_ready_o) begin
        wb_valid_o      <= !(flush_i || flush_q) && !misalign_hit;
        wb_reg_we_o     <= ex_reg_we_i;
        wb_wdata_mux_o  <= ex_wdata_mux_i;
        wb_dest_reg_o   <= ex_dest_reg_i;
        wb_alu_result_o <= ex_alu_result_i;
        wb_mem_data_o   <= (state == MEM_WAIT_RVALID) ? load_data : '0;
      end
      case (state)
        MEM_IDLE: begin
          flush_q <= issue && flush_i;
          if (issue) state <= data_gnt_i ? MEM_WAIT_RVALID : MEM_WAIT_GNT;
        end
        MEM_WAIT_GNT: begin
          flush_q <= flush_q | flush_i;
          if (data_gnt_i) state <= MEM_WAIT_RVALID;
        end
        MEM_WAIT_RVALID: begin
          flush_q <= flush_q | flush_i;
          if (data_rvalid_i) begin
            state   <= MEM_IDLE;
            flush_q <= 1'b0;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_o <= 1'b0;
    else        misalign_o <= misalign_hit && (state == MEM_IDLE);
  end
`endif

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Directed bench for riscv_mem_stage with a timed WB scoreboard and literal pins.
module tb_riscv_mem_stage;
  import riscv_cpu_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       flush_i;
  logic                       ex_valid_i;
  logic                       ex_ready_o;
  logic [31:0]                ex_alu_result_i;
  logic [31:0]                ex_mem_wdata_i;
  logic                       ex_mem_we_i;
  logic                       ex_mem_re_i;
  logic [2:0]                 ex_mem_funct3_i;
  logic                       ex_reg_we_i;
  logic [WDATA_MUX_WIDTH-1:0] ex_wdata_mux_i;
  logic [4:0]                 ex_dest_reg_i;
  logic                       data_req_o;
  logic                       data_gnt_i;
  logic [31:0]                data_addr_o;
  logic                       data_we_o;
  logic [3:0]                 data_be_o;
  logic [31:0]                data_wdata_o;
  logic                       data_rvalid_i;
  logic [31:0]                data_rdata_i;
  logic                       wb_valid_o;
  logic                       wb_reg_we_o;
  logic [WDATA_MUX_WIDTH-1:0] wb_wdata_mux_o;
  logic [4:0]                 wb_dest_reg_o;
  logic [31:0]                wb_alu_result_o;
  logic [31:0]                wb_mem_data_o;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  logic                       misalign_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic run = 1'b0;

  typedef struct {
    int                         cyc;
    logic                       reg_we;
    logic [WDATA_MUX_WIDTH-1:0] mux;
    logic [4:0]                 dest;
    logic [31:0]                alu;
    logic [31:0]                mem;
  } wb_exp_t;
  wb_exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_alu_result_i(ex_alu_result_i), .ex_mem_wdata_i(ex_mem_wdata_i),
    .ex_mem_we_i(ex_mem_we_i), .ex_mem_re_i(ex_mem_re_i), .ex_mem_funct3_i(ex_mem_funct3_i),
    .ex_reg_we_i(ex_reg_we_i), .ex_wdata_mux_i(ex_wdata_mux_i), .ex_dest_reg_i(ex_dest_reg_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_reg_we_o(wb_reg_we_o), .wb_wdata_mux_o(wb_wdata_mux_o),
    .wb_dest_reg_o(wb_dest_reg_o), .wb_alu_result_o(wb_alu_result_o), .wb_mem_data_o(wb_mem_data_o)
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: byte/halfword picked arithmetically from the word, then extended.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int off = int'(a[1:0]);
    logic [31:0] b = (rd >> (8 * off)) & 32'hFF;
    logic [31:0] h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      LB:      return b[7] ? (b | 32'hFFFFFF00) : b;
      LH:      return h[15] ? (h | 32'hFFFF0000) : h;
      LBU:     return b;
      LHU:     return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a[1:0]);
    case (f3)
      SB:      return 4'(1 << off);
      SH:      return 4'(3 << (2 * (off / 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      SB:      return {24'b0, d[7:0]} * 32'h01010101;
      SH:      return {16'b0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic re, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic rwe, input logic [WDATA_MUX_WIDTH-1:0] mux,
                       input logic [4:0] dest, input logic fl,
                       input int gd, input int rdly, input logic [31:0] rdat);
    wb_exp_t e;
    int sz;
    e.reg_we = rwe; e.mux = mux; e.dest = dest; e.alu = addr; e.mem = 32'b0;
    sz = 1 << int'(f3[1:0]);
    ex_valid_i = 1'b1; ex_mem_re_i = re; ex_mem_we_i = we; ex_mem_funct3_i = f3;
    ex_alu_result_i = addr; ex_mem_wdata_i = wd; ex_reg_we_i = rwe;
    ex_wdata_mux_i = mux; ex_dest_reg_i = dest; flush_i = fl;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    if ((re || we) && (int'(addr[1:0]) % sz) != 0) begin
      #1;
      chk("trap_ready", 32'(ex_ready_o), 1);
      chk("trap_no_req", 32'(data_req_o), 0);
      next;
      ex_valid_i = 1'b0; flush_i = 1'b0;
      chk("trap_pulse", 32'(misalign_o), 1);
      next;
      chk("trap_pulse_end", 32'(misalign_o), 0);
      chk("trap_no_req2", 32'(data_req_o), 0);
      return;
    end
`endif
    if (!re && !we) begin
      #1;
      chk("alu_ready", 32'(ex_ready_o), 1);
      chk("alu_no_req", 32'(data_req_o), 0);
      e.cyc = cyc + 1;
      if (!fl) q.push_back(e);
      next;
      ex_valid_i = 1'b0; flush_i = 1'b0;
      return;
    end
    for (int g = 0; g <= gd; g++) begin
      data_gnt_i = (g == gd);
      #1;
      chk("req_hi", 32'(data_req_o), 1);
      chk("req_ready_lo", 32'(ex_ready_o), 0);
      chk("req_addr", data_addr_o, {addr[31:2], 2'b00});
      chk("req_we", 32'(data_we_o), 32'(we));
      chk("req_be", 32'(data_be_o), 32'(we ? m_be(f3, addr) : 4'hF));
      if (we) chk("req_wdata", data_wdata_o, m_wdata(f3, wd));
      next;
      flush_i = 1'b0;
    end
    data_gnt_i = 1'b0;
    for (int r = 0; r < rdly; r++) begin
      #1;
      chk("wait_req_lo", 32'(data_req_o), 0);
      chk("wait_ready_lo", 32'(ex_ready_o), 0);
      next;
    end
    data_rvalid_i = 1'b1; data_rdata_i = rdat;
    #1;
    chk("rv_ready", 32'(ex_ready_o), 1);
    chk("rv_req_lo", 32'(data_req_o), 0);
    e.cyc = cyc + 1;
    e.mem = re ? m_load(f3, addr, rdat) : 32'b0;
    if (!fl) q.push_back(e);
    next;
    data_rvalid_i = 1'b0; data_rdata_i = 32'h5A5A_A5A5; ex_valid_i = 1'b0;
    ex_mem_re_i = 1'b0; ex_mem_we_i = 1'b0;
  endtask

  // Per-cycle WB comparison against the scheduled expectations.
  always @(negedge clk) begin
    wb_exp_t e;
    if (run) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("wb_valid", 32'(wb_valid_o), 1);
        chk("wb_reg_we", 32'(wb_reg_we_o), 32'(e.reg_we));
        chk("wb_mux", 32'(wb_wdata_mux_o), 32'(e.mux));
        chk("wb_dest", 32'(wb_dest_reg_o), 32'(e.dest));
        chk("wb_alu", wb_alu_result_o, e.alu);
        chk("wb_mem", wb_mem_data_o, e.mem);
      end else begin
        chk("wb_valid_idle", 32'(wb_valid_o), 0);
      end
    end
  end

  initial begin
    rst_n = 1'b1; flush_i = 1'b0; ex_valid_i = 1'b0; ex_alu_result_i = '0;
    ex_mem_wdata_i = '0; ex_mem_we_i = 1'b0; ex_mem_re_i = 1'b0; ex_mem_funct3_i = '0;
    ex_reg_we_i = 1'b0; ex_wdata_mux_i = WDATA_ALU; ex_dest_reg_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid_o), 0);
    chk("rst_wb_reg_we", 32'(wb_reg_we_o), 0);
    chk("rst_wb_dest", 32'(wb_dest_reg_o), 0);
    chk("rst_wb_alu", wb_alu_result_o, 0);
    chk("rst_wb_mem", wb_mem_data_o, 0);
    chk("rst_req", 32'(data_req_o), 0);
    rst_n = 1'b1;
    run = 1'b1;
    next;

    chk("pin_lb", m_load(LB, 32'h103, 32'h80FFFFFF), 32'hFFFFFF80);
    chk("pin_lbu", m_load(LBU, 32'h103, 32'h80FFFFFF), 32'h00000080);
    chk("pin_lh", m_load(LH, 32'h102, 32'h80017FFF), 32'hFFFF8001);
    chk("pin_sh_be", 32'(m_be(SH, 32'h202)), 32'hC);
    chk("pin_sh_wd", m_wdata(SH, 32'hABCD1234), 32'h12341234);
    chk("pin_sb_be", 32'(m_be(SB, 32'h301)), 32'h2);

    issue(0, 0, LW, 32'h1234, 0, 1, WDATA_ALU, 5, 0, 0, 0, 0);
    chk("lit_alu_valid", 32'(wb_valid_o), 1);
    chk("lit_alu_res", wb_alu_result_o, 32'h1234);
    chk("lit_alu_dest", 32'(wb_dest_reg_o), 5);

    issue(1, 0, LB, 32'h103, 0, 1, WDATA_MEM, 7, 0, 0, 0, 32'h80FFFFFF);
    chk("lit_lb", wb_mem_data_o, 32'hFFFFFF80);
    issue(1, 0, LBU, 32'h103, 0, 1, WDATA_MEM, 8, 0, 0, 0, 32'h80FFFFFF);
    chk("lit_lbu", wb_mem_data_o, 32'h00000080);

    issue(0, 1, SH, 32'h202, 32'hABCD1234, 0, WDATA_ALU, 0, 0, 3, 0, 32'hFFFF0000);
    chk("lit_sh_mem", wb_mem_data_o, 0);

    issue(1, 0, LW, 32'h400, 0, 1, WDATA_MEM, 9, 0, 0, 1, 32'hDEADBEEF);
    chk("lit_lw", wb_mem_data_o, 32'hDEADBEEF);
    issue(1, 0, LW, 32'h404, 0, 1, WDATA_MEM, 10, 1, 1, 0, 32'h11223344);
    chk("flush_no_valid", 32'(wb_valid_o), 0);

    issue(1, 0, LH, 32'h102, 0, 1, WDATA_MEM, 11, 0, 0, 0, 32'h80017FFF);
    issue(1, 0, LHU, 32'h100, 0, 1, WDATA_MEM, 12, 0, 2, 0, 32'h1234F00D);
    chk("lit_lhu", wb_mem_data_o, 32'h0000F00D);
    issue(0, 1, SB, 32'h301, 32'h00000055, 0, WDATA_ALU, 0, 0, 0, 0, 32'h0);
    issue(0, 1, SW, 32'h500, 32'hCAFEF00D, 0, WDATA_ALU, 0, 0, 1, 2, 32'h0);
    issue(1, 0, LW, 32'h101, 0, 1, WDATA_MEM, 13, 0, 0, 0, 32'h89ABCDEF);

    // Reset while waiting for rvalid; a late rvalid must be ignored.
    ex_valid_i = 1'b1; ex_mem_re_i = 1'b1; ex_mem_funct3_i = LW;
    ex_alu_result_i = 32'h300; ex_dest_reg_i = 5'd14; ex_reg_we_i = 1'b1; data_gnt_i = 1'b1;
    #1 chk("rr_req", 32'(data_req_o), 1);
    next;
    data_gnt_i = 1'b0;
    #1 chk("rr_wait_req", 32'(data_req_o), 0);
    ex_valid_i = 1'b0; ex_mem_re_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rr_wb_mem", wb_mem_data_o, 0);
    chk("rr_wb_alu", wb_alu_result_o, 0);
    next;
    rst_n = 1'b1;
    next;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFEEDFACE;
    #1 chk("rr_rv_ready", 32'(ex_ready_o), 0);
    next;
    data_rvalid_i = 1'b0;
    chk("rr_wb_valid", 32'(wb_valid_o), 0);
    chk("rr_wb_mem2", wb_mem_data_o, 0);
    chk("rr_wb_dest", 32'(wb_dest_reg_o), 0);

    issue(0, 0, LW, 32'hBEEF, 0, 1, WDATA_ALU, 3, 0, 0, 0, 0);
    chk("post_rst_alu", wb_alu_result_o, 32'hBEEF);
    repeat (3) next;
    chk("q_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
